// File: rtl/mem_responder.sv
// Word-addressed memory responder: accepts one read/write request, waits a
// fixed number of cycles, then completes with a one-cycle ack (plus err if misaligned).
module mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        memWriteOrRead,
    input  logic [31:0] address,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        ack,
    output logic        busy,
    output logic        err,
    output logic [1:0]  dbg_state_o
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    // Handshake: req is sampled on a rising edge only while the block is idle
    // (busy low); it is ignored otherwise and never queued. Completion is the
    // single cycle with ack high; err accompanies ack for misaligned requests,
    // and busy falls on the edge that ends the ack cycle.
    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             dout_q, dout_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic [31:0]             mem_q [DEPTH];

    logic                    misaligned;
    logic [ADDR_WIDTH-3:0]   word_idx;
    logic                    mem_we;
    logic                    unused_addr_bits;

    assign misaligned       = (addr_q[1:0] != 2'b00);
    assign word_idx         = addr_q[ADDR_WIDTH-1:2];
    assign unused_addr_bits = ^address[31:ADDR_WIDTH];

    // WAIT always spends WAIT_CYCLES+1 cycles; the extra cycle is the array
    // read that lands dataOut in the same cycle ack rises.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = memWriteOrRead;
                    addr_d  = address[ADDR_WIDTH-1:0];
                    wdata_d = dataIn;
                    cnt_d   = 4'(WAIT_CYCLES);
                    busy_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESPOND;
                    ack_d   = 1'b1;
                    err_d   = misaligned;
                    if (!wr_q && !misaligned) begin
                        dout_d = mem_q[word_idx];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESPOND: begin
                // Write commits on the edge that closes the ack cycle.
                mem_we  = wr_q && !err_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            dout_q  <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (mem_we) begin
            mem_q[word_idx] <= wdata_q;
        end
    end

    assign dataOut     = dout_q;
    assign ack         = ack_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: DUT a uses WAIT_CYCLES=1, DUT b uses WAIT_CYCLES=0.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_a, req_b;
    logic        wr;
    logic [31:0] address;
    logic [31:0] dataIn;
    logic [31:0] dout_a, dout_b;
    logic        ack_a, ack_b, busy_a, busy_b, err_a, err_b;
    logic [1:0]  dbg_a, dbg_b;

    int checks   = 0;
    int failures = 0;

    mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_dut_a (
        .clk(clk), .reset(reset), .req(req_a), .memWriteOrRead(wr),
        .address(address), .dataIn(dataIn), .dataOut(dout_a), .ack(ack_a),
        .busy(busy_a), .err(err_a), .dbg_state_o(dbg_a)
    );

    mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset), .req(req_b), .memWriteOrRead(wr),
        .address(address), .dataIn(dataIn), .dataOut(dout_b), .ack(ack_b),
        .busy(busy_b), .err(err_b), .dbg_state_o(dbg_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request on DUT sel (0=a, 1=b), starting at a negedge, then
    // watches negedges until the ack has been seen and busy has fallen.
    // lat counts rising edges from the req edge to the ack cycle.
    task automatic txn(input bit sel, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit inject,
                       output int lat, output int nbusy, output int nack,
                       output logic err_s, output logic [31:0] dout_s);
        logic b_busy, b_ack;
        req_a   = !sel;
        req_b   = sel;
        wr      = w;
        address = a;
        dataIn  = d;
        @(posedge clk);
        #1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        wr     = 1'b0;
        dataIn = $urandom;
        lat    = -1;
        nbusy  = 0;
        nack   = 0;
        err_s  = 1'b0;
        dout_s = 32'hxxxx_xxxx;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            b_busy = sel ? busy_b : busy_a;
            b_ack  = sel ? ack_b : ack_a;
            if (inject && i == 0) begin
                req_a   = 1'b1;
                wr      = 1'b1;
                dataIn  = 32'h0;
                address = a;
            end
            if (inject && i == 1) begin
                req_a = 1'b0;
                wr    = 1'b0;
            end
            if (b_busy) nbusy++;
            if (b_ack) begin
                nack++;
                if (lat < 0) begin
                    lat    = i;
                    err_s  = sel ? err_b : err_a;
                    dout_s = sel ? dout_b : dout_a;
                end
            end
            if (nack > 0 && !b_busy) break;
        end
    endtask

    int          lat, nbusy, nack, acks_in_reset;
    logic        err_s;
    logic [31:0] dout_s;

    initial begin
        reset   = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        wr      = 1'b0;
        address = 32'h0;
        dataIn  = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 1: reset values and first read
        check("rst_ack", 32'(ack_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_dout", dout_a, 32'h0);
        check("rst_state", 32'(dbg_a), 32'd0);
        txn(0, 0, 32'h00, 32'h0, 0, lat, nbusy, nack, err_s, dout_s);
        check("rd0_lat", 32'(lat), 32'd2);
        check("rd0_data", dout_s, 32'h0);
        check("rd0_nack", 32'(nack), 32'd1);

        // 2: write then read back, back-to-back in the cycle after ack
        txn(0, 1, 32'h14, 32'hDEADBEEF, 0, lat, nbusy, nack, err_s, dout_s);
        check("wr14_err", 32'(err_s), 32'd0);
        check("wr14_busy", 32'(nbusy), 32'd3);
        check("wr14_lat", 32'(lat), 32'd2);
        txn(0, 0, 32'h14, 32'h0, 0, lat, nbusy, nack, err_s, dout_s);
        check("rd14_lat", 32'(lat), 32'd2);
        check("rd14_data", dout_s, 32'hDEADBEEF);
        check("rd14_busy", 32'(nbusy), 32'd3);
        check("rd14_err", 32'(err_s), 32'd0);

        // 3: misaligned write into the same word must not commit
        txn(0, 1, 32'h16, 32'h12345678, 0, lat, nbusy, nack, err_s, dout_s);
        check("mis_err", 32'(err_s), 32'd1);
        check("mis_nack", 32'(nack), 32'd1);
        check("mis_dout_hold", dout_s, 32'hDEADBEEF);
        txn(0, 0, 32'h14, 32'h0, 0, lat, nbusy, nack, err_s, dout_s);
        check("mis_rd14", dout_s, 32'hDEADBEEF);

        // 4: req during WAIT is ignored
        txn(0, 0, 32'h14, 32'h0, 1, lat, nbusy, nack, err_s, dout_s);
        check("ovl_nack", 32'(nack), 32'd1);
        check("ovl_data", dout_s, 32'hDEADBEEF);
        repeat (4) @(negedge clk);
        check("ovl_idle_busy", 32'(busy_a), 32'd0);
        txn(0, 0, 32'h14, 32'h0, 0, lat, nbusy, nack, err_s, dout_s);
        check("ovl_rd14", dout_s, 32'hDEADBEEF);

        // 5: reset during WAIT aborts the write
        req_a   = 1'b1;
        wr      = 1'b1;
        address = 32'h08;
        dataIn  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_a = 1'b0;
        wr    = 1'b0;
        @(negedge clk);
        check("abt_pre_busy", 32'(busy_a), 32'd1);
        reset = 1'b0;
        #1;
        check("abt_busy", 32'(busy_a), 32'd0);
        check("abt_state", 32'(dbg_a), 32'd0);
        acks_in_reset = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack_a) acks_in_reset++;
        end
        check("abt_noack", 32'(acks_in_reset), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        txn(0, 0, 32'h08, 32'h0, 0, lat, nbusy, nack, err_s, dout_s);
        check("abt_rd08", dout_s, 32'h0);
        txn(0, 0, 32'h14, 32'h0, 0, lat, nbusy, nack, err_s, dout_s);
        check("abt_rd14_cleared", dout_s, 32'h0);

        // 6: address wrap, then zero-wait-state instance
        txn(0, 1, 32'h104, 32'hA5A5A5A5, 0, lat, nbusy, nack, err_s, dout_s);
        txn(0, 0, 32'h04, 32'h0, 0, lat, nbusy, nack, err_s, dout_s);
        check("wrap_rd04", dout_s, 32'hA5A5A5A5);
        txn(0, 0, 32'hFFFF_FF04, 32'h0, 0, lat, nbusy, nack, err_s, dout_s);
        check("wrap_rd_hi", dout_s, 32'hA5A5A5A5);

        txn(1, 1, 32'h20, 32'h0BADF00D, 0, lat, nbusy, nack, err_s, dout_s);
        check("w0_wr_lat", 32'(lat), 32'd1);
        check("w0_wr_busy", 32'(nbusy), 32'd2);
        txn(1, 0, 32'h20, 32'h0, 0, lat, nbusy, nack, err_s, dout_s);
        check("w0_rd_lat", 32'(lat), 32'd1);
        check("w0_rd_data", dout_s, 32'h0BADF00D);
        txn(1, 0, 32'h21, 32'h0, 0, lat, nbusy, nack, err_s, dout_s);
        check("w0_mis_err", 32'(err_s), 32'd1);
        check("w0_mis_hold", dout_s, 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
